// File: rtl/ifetch_pq_if.sv
// Pipelined Wishbone read-master bundle between the prefetch-queue fetch unit
// and its instruction memory slave.
interface ifetch_pq_if;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [3:0]  sel_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        stall_i;

   modport master (
      output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
      input  dat_i, ack_i, stall_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
      output dat_i, ack_i, stall_i
   );
endinterface

// File: rtl/ifetch_pq.sv
// Prefetch-queue instruction fetch: credit-limited pipelined Wishbone reads feed
// a FWFT queue; 1- or 2-word instructions are assembled into a 64-bit IR.
module ifetch_pq #(
   parameter int unsigned FIFO_AW  = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   ifetch_pq_if.master bus,
   output logic [63:0] ir,
   output logic        ir_valid,
   output logic [31:0] pc,
   input  logic        pc_set,
   input  logic [31:0] pc_in,
   input  logic        halt,
   input  logic        stall_i
);
   localparam int unsigned DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {S_RESET, S_FETCH, S_FETCH2, S_HALT} state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d, adr_q, adr_d, low_q, low_d;
   logic [63:0]        ir_q, ir_d;
   logic               ir_valid_q, ir_valid_d;
   logic [FIFO_AW:0]   inflight_q, inflight_d, stale_q, stale_d, count_q, count_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0]        mem_q [DEPTH];
   logic               fetching, stb, accept, push, pop;
   logic [FIFO_AW+1:0] credit_used;
   logic [31:0]        head, target;

   // Words already owed to the queue count against its free space; stale ones do not.
   always_comb begin
      fetching    = (state_q == S_FETCH) || (state_q == S_FETCH2);
      credit_used = (FIFO_AW+2)'(count_q) + (FIFO_AW+2)'(inflight_q) - (FIFO_AW+2)'(stale_q);
      stb         = fetching && !pc_set && (credit_used < (FIFO_AW+2)'(DEPTH));
      accept      = stb && !bus.stall_i;
      push        = bus.ack_i && (stale_q == '0) && (state_q != S_HALT) && !pc_set;
      pop         = fetching && !pc_set && !halt && !stall_i && (count_q != '0);
      head        = mem_q[rd_ptr_q];
      target      = pc_in & 32'hFFFF_FFFC;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      low_d      = low_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      adr_d      = accept ? adr_q + 32'd4 : adr_q;
      inflight_d = inflight_q + (FIFO_AW+1)'(accept) - (FIFO_AW+1)'(bus.ack_i);
      stale_d    = stale_q - (FIFO_AW+1)'(bus.ack_i && (stale_q != '0));
      count_d    = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
      rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);

      unique case (state_q)
         S_RESET: begin
            state_d    = S_FETCH;
            ir_d       = '0;
            ir_valid_d = 1'b0;
         end
         S_HALT: begin
            ir_d       = '0;
            ir_valid_d = 1'b0;
         end
         default: begin
            if (halt) begin
               state_d = S_HALT;
               if (!stall_i) begin
                  ir_d       = '0;
                  ir_valid_d = 1'b0;
               end
            end else if (!stall_i) begin
               if (pop) begin
                  pc_d = pc_q + 32'd4;
                  if (state_q == S_FETCH2) begin
                     ir_d       = {head, low_q};
                     ir_valid_d = 1'b1;
                     state_d    = S_FETCH;
                  end else if (head[0]) begin
                     low_d      = head;
                     ir_d       = '0;
                     ir_valid_d = 1'b0;
                     state_d    = S_FETCH2;
                  end else begin
                     ir_d       = {32'h0, head};
                     ir_valid_d = 1'b1;
                  end
               end else begin
                  ir_d       = '0;
                  ir_valid_d = 1'b0;
               end
            end
         end
      endcase

      // Redirect: every request still outstanding now belongs to the old stream.
      if (pc_set) begin
         pc_d       = target;
         adr_d      = target;
         ir_d       = '0;
         ir_valid_d = 1'b0;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         stale_d    = inflight_q - (FIFO_AW+1)'(bus.ack_i);
         state_d    = S_RESET;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_RESET;
         pc_q       <= RESET_PC;
         adr_q      <= RESET_PC;
         low_q      <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         inflight_q <= '0;
         stale_q    <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         adr_q      <= adr_d;
         low_q      <= low_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         inflight_q <= inflight_d;
         stale_q    <= stale_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= bus.dat_i;
   end

   assign bus.cyc_o = stb || (inflight_q != '0);
   assign bus.stb_o = stb;
   assign bus.we_o  = 1'b0;
   assign bus.sel_o = 4'hf;
   assign bus.adr_o = adr_q;
   assign bus.dat_o = '0;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign pc        = pc_q;
endmodule
